// File: rtl/wash_pkg.sv
// Shared constants for the washing-machine display path: time widths, digit index type and
// active-low 7-segment codes {g,f,e,d,c,b,a}.
package wash_pkg;

  localparam int unsigned TT_W = 6;
  localparam int unsigned TM_W = 5;

  typedef logic [1:0] dig_idx_t;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/wash_seg_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; codes above 9 render dark.
module wash_seg_decode
  import wash_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/wash_seg_scan.sv
// 4-digit multiplexed display scanner: digits 3..2 total time, 1..0 stage time, frame-coherent
// input snapshot. Define WASH_SEG_LZB_EN to blank leading zeros of the tens digits.
module wash_seg_scan
  import wash_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIG_N    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TT_W-1:0] tt,
  input  logic [TM_W-1:0] tm,
  input  logic            blank,
  output logic [6:0]      C,
  output logic [3:0]      A,
  output dig_idx_t        dig_idx,
  output logic            frame
);

  localparam int unsigned PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam dig_idx_t    LAST_IDX = dig_idx_t'(DIG_N - 1);

  logic [PW-1:0]   presc;
  logic            tick;
  logic [TT_W-1:0] tt_s, tt_rem;
  logic [TM_W-1:0] tm_s, tm_rem;
  logic [3:0]      tt_tens, tm_tens, digit;
  logic            tt_dark, tm_dark;
  logic [6:0]      seg;

  assign tick = (presc == PW'(SCAN_DIV - 1));

  // Decimal split by threshold compares; operands are at most 63, so no divider is needed.
  always_comb begin
    tt_tens = 4'd0;
    tm_tens = 4'd0;
    for (int k = 1; k <= 6; k++) begin
      if (tt_s >= TT_W'(k * 10)) tt_tens = 4'(k);
    end
    for (int k = 1; k <= 3; k++) begin
      if (tm_s >= TM_W'(k * 10)) tm_tens = 4'(k);
    end
    tt_rem = tt_s - TT_W'(tt_tens * 4'd10);
    tm_rem = tm_s - TM_W'(tm_tens * 4'd10);
  end

`ifdef WASH_SEG_LZB_EN
  assign tt_dark = (tt_s < TT_W'(10));
  assign tm_dark = (tm_s < TM_W'(10));
`else
  assign tt_dark = 1'b0;
  assign tm_dark = 1'b0;
`endif

  // Code 0xF decodes to all segments off, used for a blanked tens digit.
  always_comb begin
    digit = 4'hF;
    case (dig_idx)
      2'd0: digit = tm_rem[3:0];
      2'd1: digit = tm_dark ? 4'hF : tm_tens;
      2'd2: digit = tt_rem[3:0];
      2'd3: digit = tt_dark ? 4'hF : tt_tens;
      default: digit = 4'hF;
    endcase
  end

  wash_seg_decode u_decode (
    .digit (digit),
    .seg   (seg)
  );

  // A and C are loaded on the same edge so anode and segment pattern never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      dig_idx <= '0;
      tt_s    <= '0;
      tm_s    <= '0;
      A       <= 4'b1111;
      C       <= SEG_OFF;
      frame   <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      frame <= 1'b0;
      if (tick) begin
        if (dig_idx == LAST_IDX) begin
          dig_idx <= '0;
          tt_s    <= tt;
          tm_s    <= tm;
          frame   <= 1'b1;
        end else begin
          dig_idx <= dig_idx + 1'b1;
        end
      end
      if (blank) begin
        A <= 4'b1111;
        C <= SEG_OFF;
      end else begin
        A <= ~(4'b0001 << dig_idx);
        C <= seg;
      end
    end
  end

endmodule

// File: tb/tb_wash_seg_scan.sv
// Self-checking bench for wash_seg_scan: cycle-level reference model, digit table and
// directed sequences for snapshot coherence, blanking and mid-frame reset.
module tb_wash_seg_scan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int FRAME_LEN = SCAN_DIV * 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SOFF = 7'b1111111;

`ifdef WASH_SEG_LZB_EN
  localparam bit LZB = 1'b1;
  localparam logic [6:0] LZ = SOFF;
`else
  localparam bit LZB = 1'b0;
  localparam logic [6:0] LZ = S0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] tt;
  logic [4:0] tm;
  logic       blank;
  logic [6:0] C;
  logic [3:0] A;
  logic [1:0] dig_idx;
  logic       frame;

  wash_seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DIG_N    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tt      (tt),
    .tm      (tm),
    .blank   (blank),
    .C       (C),
    .A       (A),
    .dig_idx (dig_idx),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic [6:0] seg_tab [0:9] = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9};

  // Reference: edges since reset and the values latched at each frame boundary.
  int cnt = 0;
  int m_tt = 0;
  int m_tm = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int idx, input int t, input int m);
    int  d;
    bit  dark;
    dark = 1'b0;
    d = 0;
    case (idx)
      0: d = m % 10;
      1: begin d = m / 10; dark = LZB && (m < 10); end
      2: d = t % 10;
      default: begin d = t / 10; dark = LZB && (t < 10); end
    endcase
    return dark ? SOFF : seg_tab[d];
  endfunction

  task automatic tick();
    int idx;
    logic [3:0] ea;
    logic [6:0] ec;
    logic ef;
    logic [3:0] one;
    one = 4'b0001;
    @(posedge clk);
    if (rst) begin
      cnt = 0; m_tt = 0; m_tm = 0;
      ea = 4'hF; ec = SOFF; ef = 1'b0;
    end else begin
      idx = (cnt / SCAN_DIV) % 4;
      if (blank) begin
        ea = 4'hF; ec = SOFF;
      end else begin
        ea = ~(one << idx);
        ec = ref_seg(idx, m_tt, m_tm);
      end
      ef = ((cnt % FRAME_LEN) == FRAME_LEN - 1);
      if (ef) begin m_tt = int'(tt); m_tm = int'(tm); end
      cnt++;
    end
    #1;
    chk("model_A", 32'(A), 32'(ea));
    chk("model_C", 32'(C), 32'(ec));
    chk("model_frame", 32'(frame), 32'(ef));
    chk("model_dig_idx", 32'(dig_idx), 32'((cnt / SCAN_DIV) % 4));
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME_LEN && !seen; i++) begin
      tick();
      seen = frame;
    end
    chk("frame_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_anode(input logic [3:0] pat);
    bit seen;
    seen = (A == pat);
    for (int i = 0; i < 3 * FRAME_LEN && !seen; i++) begin
      tick();
      seen = (A == pat);
    end
    chk("anode_wait", 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [5:0]      tt;
    logic [4:0]      tm;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t vec [6];

  initial begin
    vec[0] = '{6'd45, 5'd17, {S4, S5, S1, S7}};
    vec[1] = '{6'd63, 5'd31, {S6, S3, S3, S1}};
    vec[2] = '{6'd0,  5'd0,  {LZ, S0, LZ, S0}};
    vec[3] = '{6'd5,  5'd3,  {LZ, S5, LZ, S3}};
    vec[4] = '{6'd20, 5'd9,  {S2, S0, LZ, S9}};
    vec[5] = '{6'd38, 5'd26, {S3, S8, S2, S6}};

    rst = 1'b1; tt = '0; tm = '0; blank = 1'b0;
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_release_A", 32'(A), 32'(4'b1110));
    chk("reset_release_C", 32'(C), 32'(S0));
    for (int i = 0; i < 2 * FRAME_LEN; i++) tick();

    // Digit table: load inputs, then check one full frame slot by slot.
    for (int v = 0; v < 6; v++) begin
      tt = vec[v].tt;
      tm = vec[v].tm;
      wait_frame();
      for (int i = 0; i < FRAME_LEN; i++) begin
        tick();
        for (int s = 0; s < 4; s++) begin
          if (A[s] == 1'b0) chk($sformatf("table%0d_slot%0d", v, s), 32'(C), 32'(vec[v].exp[s]));
        end
      end
    end

    // Input change mid-frame must not leak into the current frame.
    tt = 6'd45; tm = 5'd17;
    wait_frame();
    for (int i = 0; i < FRAME_LEN && dig_idx != 2'd1; i++) tick();
    chk("coh_idx1", 32'(dig_idx), 32'd1);
    tm = 5'd9;
    wait_anode(4'b1101);
    chk("coh_old_tens", 32'(C), 32'(S1));
    wait_frame();
    wait_anode(4'b1110);
    chk("coh_new_units", 32'(C), 32'(S9));
    wait_anode(4'b1101);
    chk("coh_new_tens", 32'(C), 32'(LZ));

    // Blank for 10 clocks mid-frame.
    for (int i = 0; i < FRAME_LEN && dig_idx != 2'd2; i++) tick();
    blank = 1'b1;
    tick();
    chk("blank_A", 32'(A), 32'hF);
    chk("blank_C", 32'(C), 32'(SOFF));
    for (int i = 0; i < 9; i++) tick();
    blank = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++) tick();

    // Reset pulse while scanning slot 2 with non-zero inputs applied.
    tt = 6'd63; tm = 5'd31;
    for (int i = 0; i < FRAME_LEN && dig_idx != 2'd2; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_A", 32'(A), 32'hF);
    chk("rst_C", 32'(C), 32'(SOFF));
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_idx", 32'(dig_idx), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_restart_A", 32'(A), 32'(4'b1110));
    chk("rst_restart_C", 32'(C), 32'(S0));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) tt = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) tm = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
